usb_key_buffer: RTL

Keyboard event stage downstream of `usb_hid_host` in the `clkusb_i` domain. Each keyboard report is compared against the previous one to find newly pressed keys. New keys are converted to ASCII and queued in a small first-word-fall-through FIFO, with typematic auto-repeat for a held key. The CPU-side register block drains the queue through a pop strobe, so no keystroke is lost between polls.

---
 rtl/usb_hid_pkg.sv | 70 +++++++
 rtl/usb_key_fifo.sv | 60 ++++++
 rtl/usb_key_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB HID keyboard path: device types, modifier
// masks, controller states and the HID usage-to-ASCII translation.
package usb_hid_pkg;

  typedef enum logic [1:0] {
    TYP_NONE  = 2'd0,
    TYP_KBD   = 2'd1,
    TYP_MOUSE = 2'd2,
    TYP_GAME  = 2'd3
  } typ_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } kbd_state_e;

  localparam logic [7:0] KEY_ROLLOVER = 8'h01;
  // Left and right variants of each modifier are treated alike.
  localparam logic [7:0] SHIFT_MASK   = 8'h22;
  localparam logic [7:0] CTRL_MASK    = 8'h11;

  // Returns 0 for usages with no printable/control ASCII equivalent.
  function automatic logic [7:0] scancode2char(input logic [7:0] key,
                                               input logic [7:0] mods);
    logic       shift;
    logic       ctrl;
    logic [7:0] c;
    shift = |(mods & SHIFT_MASK);
    ctrl  = |(mods & CTRL_MASK);
    c     = 8'h00;
    if (key >= 8'h04 && key <= 8'h1D) begin
      if (ctrl)       c = key - 8'h03;
      else if (shift) c = key + 8'h3D;
      else            c = key + 8'h5D;
    end else begin
      case (key)
        8'h1E: c = shift ? 8'h21 : 8'h31;
        8'h1F: c = shift ? 8'h40 : 8'h32;
        8'h20: c = shift ? 8'h23 : 8'h33;
        8'h21: c = shift ? 8'h24 : 8'h34;
        8'h22: c = shift ? 8'h25 : 8'h35;
        8'h23: c = shift ? 8'h5E : 8'h36;
        8'h24: c = shift ? 8'h26 : 8'h37;
        8'h25: c = shift ? 8'h2A : 8'h38;
        8'h26: c = shift ? 8'h28 : 8'h39;
        8'h27: c = shift ? 8'h29 : 8'h30;
        8'h28: c = 8'h0D;
        8'h29: c = 8'h1B;
        8'h2A: c = 8'h08;
        8'h2B: c = 8'h09;
        8'h2C: c = 8'h20;
        8'h2D: c = shift ? 8'h5F : 8'h2D;
        8'h2E: c = shift ? 8'h2B : 8'h3D;
        8'h2F: c = shift ? 8'h7B : 8'h5B;
        8'h30: c = shift ? 8'h7D : 8'h5D;
        8'h31: c = shift ? 8'h7C : 8'h5C;
        8'h33: c = shift ? 8'h3A : 8'h3B;
        8'h34: c = shift ? 8'h22 : 8'h27;
        8'h35: c = shift ? 8'h7E : 8'h60;
        8'h36: c = shift ? 8'h3C : 8'h2C;
        8'h37: c = shift ? 8'h3E : 8'h2E;
        8'h38: c = shift ? 8'h3F : 8'h2F;
        default: c = 8'h00;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_key_fifo.sv
// First-word-fall-through FIFO for decoded key characters. A push into a full
// FIFO succeeds only when a pop frees the head in the same cycle.
module usb_key_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_eff;
  logic          pop_eff;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop_i && !empty_o;
  assign push_eff = push_i && (!full_o || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_eff && !pop_eff)      count_d = count_q + 1'b1;
    else if (!push_eff && pop_eff) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_eff) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/usb_key_buffer.sv
// Turns HID keyboard reports into a queue of ASCII keystrokes: detects newly
// pressed keys against the previous report and auto-repeats the latest one.
module usb_key_buffer
  import usb_hid_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned REP_DELAY = 6000000,
  parameter int unsigned REP_RATE  = 400000
) (
  input  logic                   clkusb_i,
  input  logic                   rst_n_i,
  input  logic                   report_i,
  input  logic [1:0]             typ_i,
  input  logic [7:0]             key_modifiers_i,
  input  logic [7:0]             key1_i,
  input  logic [7:0]             key2_i,
  input  logic [7:0]             key3_i,
  input  logic [7:0]             key4_i,
  input  logic                   pop_i,
  input  logic                   clr_ovf_i,
  output logic [7:0]             data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int unsigned CNT_W   = $clog2(REP_MAX + 1);

  kbd_state_e state_q, state_d;

  logic [7:0]       key_in [4];
  logic [7:0]       key_q  [4];
  logic [7:0]       key_d  [4];
  logic [7:0]       prev_q [4];
  logic [7:0]       prev_d [4];
  logic [7:0]       mods_q, mods_d;
  logic [1:0]       idx_q, idx_d;
  logic             rep_valid_q, rep_valid_d;
  logic [7:0]       rep_key_q, rep_key_d;
  logic [7:0]       rep_char_q, rep_char_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             ovf_q, ovf_d;

  logic       rpt_kbd;
  logic       rpt_other;
  logic [7:0] cur_key;
  logic [7:0] scan_char;
  logic       in_prev;
  logic       rep_in_latched;
  logic       scan_push;
  logic       rep_fire;
  logic       push;
  logic [7:0] push_data;
  logic       fifo_full;

  assign key_in[0] = key1_i;
  assign key_in[1] = key2_i;
  assign key_in[2] = key3_i;
  assign key_in[3] = key4_i;

  // Reports are only accepted while idle; anything arriving mid-scan is lost.
  assign rpt_kbd   = (state_q == ST_IDLE) && report_i && (typ_i == TYP_KBD) &&
                     (key1_i != KEY_ROLLOVER);
  assign rpt_other = (state_q == ST_IDLE) && report_i && (typ_i != TYP_KBD);

  assign cur_key   = key_q[idx_q];
  assign scan_char = scancode2char(cur_key, mods_q);

  always_comb begin
    in_prev        = 1'b0;
    rep_in_latched = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (prev_q[j] == cur_key)  in_prev        = 1'b1;
      if (key_q[j]  == rep_key_q) rep_in_latched = 1'b1;
    end
  end

  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (rpt_kbd) state_d = ST_SCAN;
      ST_SCAN:   if (idx_q == 2'd3) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scan_push = (state_q == ST_SCAN) && (cur_key != 8'h00) && !in_prev &&
                (scan_char != 8'h00);
    rep_fire  = rep_valid_q && (rep_cnt_q == CNT_W'(1));
    push      = scan_push || rep_fire;
    push_data = scan_push ? scan_char : rep_char_q;
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      key_d[j]  = rpt_kbd ? key_in[j] : key_q[j];
      prev_d[j] = prev_q[j];
      if (rpt_other)                 prev_d[j] = 8'h00;
      else if (state_q == ST_UPDATE) prev_d[j] = key_q[j];
    end
    mods_d = rpt_kbd ? key_modifiers_i : mods_q;
    idx_d  = idx_q;
    if (rpt_kbd)                   idx_d = 2'd0;
    else if (state_q == ST_SCAN)   idx_d = idx_q + 2'd1;

    rep_valid_d = rep_valid_q;
    rep_key_d   = rep_key_q;
    rep_char_d  = rep_char_q;
    rep_cnt_d   = rep_cnt_q;
    if (rpt_other) begin
      rep_valid_d = 1'b0;
      rep_key_d   = 8'h00;
      rep_char_d  = 8'h00;
      rep_cnt_d   = '0;
    end else if (scan_push) begin
      rep_valid_d = 1'b1;
      rep_key_d   = cur_key;
      rep_char_d  = scan_char;
      rep_cnt_d   = CNT_W'(REP_DELAY);
    end else if (state_q == ST_UPDATE && !rep_in_latched) begin
      rep_valid_d = 1'b0;
      rep_key_d   = 8'h00;
      rep_char_d  = 8'h00;
      rep_cnt_d   = '0;
    end else if (rep_valid_q) begin
      rep_cnt_d = rep_fire ? CNT_W'(REP_RATE) : rep_cnt_q - 1'b1;
    end

    // A dropped push must win over a simultaneous clear.
    ovf_d = ovf_q;
    if (push && fifo_full && !pop_i) ovf_d = 1'b1;
    else if (clr_ovf_i)              ovf_d = 1'b0;
  end

  always_ff @(posedge clkusb_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int j = 0; j < 4; j++) begin
        key_q[j]  <= 8'h00;
        prev_q[j] <= 8'h00;
      end
      mods_q      <= 8'h00;
      idx_q       <= 2'd0;
      rep_valid_q <= 1'b0;
      rep_key_q   <= 8'h00;
      rep_char_q  <= 8'h00;
      rep_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        key_q[j]  <= key_d[j];
        prev_q[j] <= prev_d[j];
      end
      mods_q      <= mods_d;
      idx_q       <= idx_d;
      rep_valid_q <= rep_valid_d;
      rep_key_q   <= rep_key_d;
      rep_char_q  <= rep_char_d;
      rep_cnt_q   <= rep_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  usb_key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clkusb_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .pop_i   (pop_i),
    .data_i  (push_data),
    .data_o  (data_o),
    .count_o (count_o),
    .empty_o (empty_o),
    .full_o  (fifo_full)
  );

  assign overflow_o = ovf_q;

endmodule
